// File: rtl/riscv_pipe_pkg.sv
// Shared widths, ALU select encodings and packed decode-control layout for the
// ID/EX operand stage.
package riscv_pipe_pkg;

  localparam int XLEN   = 32;
  localparam int RA_W   = 5;
  localparam int CTRL_W = 10;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  // MSB first: mem_to_reg is bit 9, alu_sel occupies bits 3:0.
  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       a_pc;
    logic       alu_src;
    logic [3:0] alu_sel;
  } ctrl_t;

endpackage

// File: rtl/fwd_select.sv
// Operand bypass mux: EX/MEM beats MEM/WB beats the register-file value;
// x0 is never bypassed.
module fwd_select
  import riscv_pipe_pkg::*;
(
  input  logic [RA_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic            exmem_reg_write_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [XLEN-1:0] fwd_data_o
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i);
  assign hit_memwb = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i);

  always_comb begin
    fwd_data_o = rs_data_i;
    if (hit_exmem)      fwd_data_o = exmem_result_i;
    else if (hit_memwb) fwd_data_o = memwb_data_i;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX operand
// forwarding/selection feeding the ALU and the store-data path.
module id_ex_operand_stage
  import riscv_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [1:0]        id_uses_rs,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              exmem_reg_write,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [RA_W-1:0]   ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_sel,
  output logic [XLEN-1:0]   store_data
);

  logic            valid_q,    valid_d;
  ctrl_t           ctrl_q,     ctrl_d;
  logic [RA_W-1:0] rd_q,       rd_d;
  logic [RA_W-1:0] rs1_q,      rs1_d;
  logic [RA_W-1:0] rs2_q,      rs2_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;

  logic            load_use;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  assign load_use = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                    ((id_uses_rs[0] && (id_rs1 == rd_q)) ||
                     (id_uses_rs[1] && (id_rs2 == rd_q)));

  assign stall_o = (load_use || hold_i) && !flush_i;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    // Flush and bubble only clear valid/ctrl; the data fields are don't-care.
    if (flush_i || (!hold_i && load_use)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!hold_i) begin
      valid_d    = id_valid;
      ctrl_d     = id_valid ? ctrl_t'(id_ctrl) : '0;
      rd_d       = id_rd;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  fwd_select u_fwd_rs1 (
    .rs_addr_i         (rs1_q),
    .rs_data_i         (rs1_data_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_data_i      (memwb_data),
    .fwd_data_o        (fwd_rs1)
  );

  fwd_select u_fwd_rs2 (
    .rs_addr_i         (rs2_q),
    .rs_data_i         (rs2_data_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_data_i      (memwb_data),
    .fwd_data_o        (fwd_rs2)
  );

  assign ex_valid   = valid_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_rd      = rd_q;
  assign ex_pc      = pc_q;
  assign alu_sel    = ctrl_q.alu_sel;
  assign alu_a      = ctrl_q.a_pc    ? pc_q  : fwd_rs1;
  assign alu_b      = ctrl_q.alu_src ? imm_q : fwd_rs2;
  assign store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage: reset, operand selection,
// forwarding priority, load-use bubble, flush/hold and store data.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_uses_rs;
  logic [9:0]  id_ctrl;
  logic        flush_i, hold_i;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic        stall_o, ex_valid;
  logic [9:0]  ex_ctrl;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, alu_a, alu_b, store_data;
  logic [3:0]  alu_sel;

  int n_vec = 0;
  int n_err = 0;

  // ctrl encodings: ADD=0x002, alu_src=0x010, reg_write=0x040,
  // mem_read=0x080, mem_write=0x100, mem_to_reg=0x200
  localparam logic [9:0] C_ADDI = 10'h052;
  localparam logic [9:0] C_ADD  = 10'h042;
  localparam logic [9:0] C_LW   = 10'h2D2;
  localparam logic [9:0] C_SW   = 10'h112;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs(id_uses_rs),
    .id_ctrl(id_ctrl), .flush_i(flush_i), .hold_i(hold_i),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_data(memwb_data), .stall_o(stall_o),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .store_data(store_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic [31:0] imm,
                        input logic [1:0] uses, input logic [9:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
    id_rs2_data = d2; id_rd = rd; id_imm = imm; id_uses_rs = uses; id_ctrl = ctrl;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; flush_i = 0; hold_i = 0; clear_fwd();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    #12;
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %h want 0", ex_valid); end
    n_vec++; if (ex_ctrl !== 10'h0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", ex_ctrl); end
    n_vec++; if (ex_rd !== 5'h0) begin n_err++; $display("FAIL reset_rd got %h want 0", ex_rd); end
    n_vec++; if (ex_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", ex_pc); end
    n_vec++; if ({alu_a, alu_b, store_data} !== 96'h0) begin n_err++; $display("FAIL reset_operands got %h %h %h want 0", alu_a, alu_b, store_data); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got %h want 0", stall_o); end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_addi();
    set_id(1, 32'h100, 0, 0, 0, 0, 5, 7, 2'b01, C_ADDI);
    step();
    n_vec++; if (alu_a !== 32'h0) begin n_err++; $display("FAIL addi_a got %h want 0", alu_a); end
    n_vec++; if (alu_b !== 32'h7) begin n_err++; $display("FAIL addi_b got %h want 7", alu_b); end
    n_vec++; if (alu_sel !== 4'b0010) begin n_err++; $display("FAIL addi_sel got %b want 0010", alu_sel); end
    n_vec++; if ({ex_valid, ex_rd, ex_pc, ex_ctrl} !== {1'b1, 5'd5, 32'h100, C_ADDI}) begin
      n_err++; $display("FAIL addi_ex got v=%h rd=%h pc=%h ctrl=%h", ex_valid, ex_rd, ex_pc, ex_ctrl); end
  endtask

  task automatic test_forward_priority();
    set_id(1, 32'h104, 3, 32'h55, 0, 32'h66, 7, 0, 2'b11, C_ADD);
    step();
    id_valid = 0;
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'h22;
    #1;
    n_vec++; if (alu_a !== 32'h11) begin n_err++; $display("FAIL fwd_exmem got %h want 11", alu_a); end
    n_vec++; if (alu_b !== 32'h66) begin n_err++; $display("FAIL fwd_rs2_none got %h want 66", alu_b); end
    exmem_reg_write = 0; #1;
    n_vec++; if (alu_a !== 32'h22) begin n_err++; $display("FAIL fwd_memwb got %h want 22", alu_a); end
    memwb_reg_write = 0; #1;
    n_vec++; if (alu_a !== 32'h55) begin n_err++; $display("FAIL fwd_none got %h want 55", alu_a); end
    clear_fwd();
  endtask

  task automatic test_x0_no_forward();
    set_id(1, 32'h108, 0, 0, 0, 0, 1, 0, 2'b11, C_ADD);
    step();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'hFFFF_FFFF;
    #1;
    n_vec++; if (alu_a !== 32'h0) begin n_err++; $display("FAIL x0_a got %h want 0", alu_a); end
    n_vec++; if (store_data !== 32'h0) begin n_err++; $display("FAIL x0_store got %h want 0", store_data); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    set_id(1, 32'h200, 1, 32'h10, 0, 0, 4, 0, 2'b01, C_LW);
    step();
    set_id(1, 32'h204, 7, 32'h70, 4, 32'h40, 6, 0, 2'b11, C_ADD);
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall got %h want 1", stall_o); end
    step();
    n_vec++; if ({ex_valid, ex_ctrl} !== 11'h0) begin n_err++; $display("FAIL lu_bubble got v=%h ctrl=%h want 0", ex_valid, ex_ctrl); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_stall_drop got %h want 0", stall_o); end
    step();
    n_vec++; if ({ex_valid, ex_rd, ex_ctrl, ex_pc} !== {1'b1, 5'd6, C_ADD, 32'h204}) begin
      n_err++; $display("FAIL lu_add got v=%h rd=%h ctrl=%h pc=%h", ex_valid, ex_rd, ex_ctrl, ex_pc); end
    n_vec++; if ({alu_a, alu_b} !== {32'h70, 32'h40}) begin n_err++; $display("FAIL lu_ops got %h %h want 70 40", alu_a, alu_b); end
  endtask

  task automatic test_flush_hold();
    set_id(1, 32'h280, 1, 0, 0, 0, 4, 0, 2'b01, C_LW);
    step();
    set_id(1, 32'h284, 7, 0, 4, 0, 6, 0, 2'b11, C_ADD);
    flush_i = 1; #1;
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall got %h want 0", stall_o); end
    step();
    flush_i = 0;
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %h want 0", ex_valid); end
    set_id(1, 32'h300, 2, 0, 0, 0, 9, 32'h33, 2'b01, C_ADDI);
    step();
    set_id(1, 32'h400, 3, 0, 4, 0, 10, 0, 2'b11, C_ADD);
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d] got %h want 1", i, stall_o); end
      step();
      n_vec++; if ({ex_valid, ex_rd, ex_pc, ex_ctrl, alu_b} !== {1'b1, 5'd9, 32'h300, C_ADDI, 32'h33}) begin
        n_err++; $display("FAIL hold_ex[%0d] got v=%h rd=%h pc=%h ctrl=%h b=%h", i, ex_valid, ex_rd, ex_pc, ex_ctrl, alu_b); end
    end
    hold_i = 0;
    id_valid = 0;
    step();
    n_vec++; if ({ex_valid, ex_ctrl} !== 11'h0) begin n_err++; $display("FAIL idle_ctrl got v=%h ctrl=%h want 0", ex_valid, ex_ctrl); end
  endtask

  task automatic test_store();
    set_id(1, 32'h500, 2, 32'h1000, 8, 32'h1234, 0, 8, 2'b11, C_SW);
    step();
    memwb_reg_write = 1; memwb_rd = 8; memwb_data = 32'hABCD;
    #1;
    n_vec++; if (alu_b !== 32'h8) begin n_err++; $display("FAIL sw_b got %h want 8", alu_b); end
    n_vec++; if (store_data !== 32'hABCD) begin n_err++; $display("FAIL sw_fwd got %h want abcd", store_data); end
    n_vec++; if (alu_a !== 32'h1000) begin n_err++; $display("FAIL sw_a got %h want 1000", alu_a); end
    memwb_reg_write = 0; #1;
    n_vec++; if (store_data !== 32'h1234) begin n_err++; $display("FAIL sw_nofwd got %h want 1234", store_data); end
    clear_fwd();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 32'h600, 1, 0, 0, 0, 4, 0, 2'b01, C_LW);
    step();
    set_id(1, 32'h604, 4, 0, 0, 0, 5, 0, 2'b01, C_ADD);
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL mid_stall got %h want 1", stall_o); end
    #2 rst_n = 0; #1;
    n_vec++; if ({stall_o, ex_valid, ex_ctrl} !== 12'h0) begin
      n_err++; $display("FAIL mid_reset got stall=%h v=%h ctrl=%h want 0", stall_o, ex_valid, ex_ctrl); end
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forward_priority();
    test_x0_no_forward();
    test_load_use();
    test_flush_hold();
    test_store();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register plus EX operand-select logic directly upstream of the 32-bit ALU. Captures decoded instruction state each cycle and detects load-use hazards, inserting a bubble and stalling IF/ID. Resolves EX/MEM and MEM/WB forwarding and drives the ALU A/B operands and 4-bit op select, plus store data and control for the downstream stage.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
CTRL_W, 10, packed control width (layout in package)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID slot holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  RA_W  source 1 address
id_rs2  in  RA_W  source 2 address
id_rd  in  RA_W  destination address
id_uses_rs  in  2  bit0 rs1 read, bit1 rs2 read
id_ctrl  in  CTRL_W  packed decode control
flush_i  in  1  branch/jump redirect, kill ID/EX content
hold_i  in  1  downstream stall, freeze stage
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  RA_W  EX/MEM destination
exmem_result  in  XLEN  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  RA_W  MEM/WB destination
memwb_data  in  XLEN  MEM/WB writeback value
stall_o  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX slot valid
ex_ctrl  out  CTRL_W  registered control
ex_rd  out  RA_W  registered destination
ex_pc  out  XLEN  registered PC
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_sel  out  4  ALU op select (= ex_ctrl.alu_sel)
store_data  out  XLEN  forwarded rs2 for stores

Behaviour:
- Clock clk, reset rst_n: one clock domain, reset asynchronous, active-low.
- Reset: all registered state 0, so ex_valid=0, ex_ctrl=0, ex_rd=0, ex_pc=0. alu_a, alu_b, store_data become 0 unless forwarding matches.
- Register update at the rising edge, in priority order:
  1. flush_i: valid=0, ctrl=0.
  2. hold_i: retain all.
  3. load_use: bubble, valid=0, ctrl=0, data fields don't-care.
  4. Otherwise capture all id_* fields. ctrl is captured as 0 when id_valid=0.
- load_use (combinational) = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid & ((id_uses_rs[0] & id_rs1==ex_rd) | (id_uses_rs[1] & id_rs2==ex_rd)).
- stall_o = (load_use | hold_i) & ~flush_i. A flush overrides stall.
- Forwarding, rs1 (same rule for rs2), combinational from registered ex_rs1/ex_rs2:
  - exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs1 -> exmem_result.
  - Else memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs1 -> memwb_data.
  - Else ex_rs1_data. EX/MEM wins over MEM/WB. x0 is never forwarded.
- alu_a = ex_ctrl.a_pc ? ex_pc : fwd_rs1.
- alu_b = ex_ctrl.alu_src ? ex_imm : fwd_rs2.
- store_data = fwd_rs2, regardless of alu_src.
- Latency: 1 cycle from ID to EX outputs. Operand outputs are combinational in EX.
- A bubble carries ctrl=0 (alu_sel=AND, no reg_write, no mem access), so it is architecturally inert.
- Reset mid-stall: all state clears immediately; stall_o drops asynchronously with ex_valid.

Decomposition:
- Package riscv_pipe_pkg holds:
  - XLEN, RA_W, CTRL_W.
  - ALU select constants: AND 0000, OR 0001, ADD 0010, XOR 0100, SUB 0110, SLL 0111, SRL 1000, SRA 1001, SLT 1010, SLTU 1011.
  - Packed ctrl field offsets: alu_sel[3:0], alu_src[4], a_pc[5], reg_write[6], mem_read[7], mem_write[8], mem_to_reg[9].
- Sub-module fwd_select, instantiated twice (rs1, rs2): inputs register address and three data sources, output forwarded value.

Test Plan:
1. Reset, then ADDI x5,x0,7 (imm=7, alu_src=1, sel=0010) -> next cycle alu_a=0, alu_b=7, alu_sel=0010, ex_valid=1.
2. EX/MEM rd=x3, result=0x11; MEM/WB rd=x3, data=0x22; EX rs1=x3 -> alu_a=0x11. Clear exmem_reg_write -> alu_a=0x22.
3. Forwarding targeting x0 with exmem_result=0xFFFF_FFFF, EX rs1=x0, rs1_data=0 -> alu_a=0.
4. LW x4 in EX, ID ADD rs2=x4 -> stall_o=1 for exactly one cycle. Next cycle ex_valid=0, ex_ctrl=0. The cycle after, ADD in EX.
5. flush_i together with a load-use condition -> stall_o=0, next ex_valid=0. hold_i=1 for 3 cycles -> ex_* unchanged throughout.
6. SW with alu_src=1, imm=8, rs2 forwarded from MEM/WB=0xABCD -> alu_b=8, store_data=0xABCD.
